// File: rtl/sig_meas_pkg.sv
// Shared types and default constants for the signal period meter.
package sig_meas_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_e;

    localparam int unsigned CLK_HZ          = 100_000_000;
    localparam int unsigned DEF_TIMEOUT_CYC = CLK_HZ;
    localparam int unsigned DEF_MIN_PERIOD  = 4;

endpackage

// File: rtl/sig_period_meter_sat_counter.sv
// Saturating up-counter: clr restarts at 0, clr together with inc restarts at 1.
// Latency 1 cycle; no backpressure, holds at all-ones.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_d;
    logic [W-1:0] cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = inc ? W'(1) : '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/sig_period_meter.sv
// Measures rise-to-rise period and high time of one edge-strobed signal, flags loss of signal.
// Results appear 1 cycle after the closing rise with a one-cycle meas_valid; no backpressure.
module sig_period_meter
    import sig_meas_pkg::*;
#(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int unsigned MIN_PERIOD  = DEF_MIN_PERIOD
) (
    input  logic             clk_100m,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             sig_l2h,
    input  logic             sig_h2l,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_valid,
    output logic             sig_lost,
    output logic             edge_err,
    output logic [15:0]      glitch_cnt
);

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] MIN_VAL = CNT_W'(MIN_PERIOD);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] pend_q, pend_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_time_q, high_time_d;
    logic             meas_valid_q, meas_valid_d;
    logic             sig_lost_q, sig_lost_d;
    logic             edge_err_q, edge_err_d;

    logic [CNT_W-1:0] per_cnt, hi_cnt, to_cnt;
    logic             rise, fall, both, lost_hit, close, accept;
    logic             per_clr, per_inc, hi_inc, to_clr, glitch_inc;

    always_comb begin
        rise       = enable && sig_l2h && !sig_h2l;
        fall       = enable && sig_h2l && !sig_l2h;
        both       = enable && sig_l2h && sig_h2l;
        // Loss fires on the edge where the since-rise count reaches TIMEOUT_CYC.
        lost_hit   = enable && !rise && (to_cnt == TO_LAST);
        close      = rise && (state_q != ST_IDLE);
        accept     = (per_cnt >= MIN_VAL);
        per_clr    = !enable || rise || lost_hit;
        per_inc    = enable && !lost_hit && (rise || (state_q != ST_IDLE));
        hi_inc     = enable && !lost_hit && (rise || (state_q == ST_HIGH));
        to_clr     = !enable || rise;
        glitch_inc = close && !accept;
    end

    always_comb begin
        state_d      = state_q;
        pend_d       = pend_q;
        period_d     = period_q;
        high_time_d  = high_time_q;
        meas_valid_d = 1'b0;
        sig_lost_d   = sig_lost_q;
        edge_err_d   = edge_err_q;
        if (!enable) begin
            state_d    = ST_IDLE;
            pend_d     = '0;
            sig_lost_d = 1'b0;
            edge_err_d = 1'b0;
        end else if (lost_hit) begin
            state_d    = ST_IDLE;
            sig_lost_d = 1'b1;
            edge_err_d = edge_err_q || both;
        end else if (both) begin
            edge_err_d = 1'b1;
        end else if (rise) begin
            state_d    = ST_HIGH;
            sig_lost_d = 1'b0;
            if (close && accept) begin
                period_d     = per_cnt;
                high_time_d  = (state_q == ST_HIGH) ? hi_cnt : pend_q;
                meas_valid_d = 1'b1;
            end
        end else if (fall && (state_q == ST_HIGH)) begin
            state_d = ST_LOW;
            pend_d  = hi_cnt;
        end
    end

    always_ff @(posedge clk_100m or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            pend_q       <= '0;
            period_q     <= '0;
            high_time_q  <= '0;
            meas_valid_q <= 1'b0;
            sig_lost_q   <= 1'b0;
            edge_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_q       <= pend_d;
            period_q     <= period_d;
            high_time_q  <= high_time_d;
            meas_valid_q <= meas_valid_d;
            sig_lost_q   <= sig_lost_d;
            edge_err_q   <= edge_err_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_per_cnt (
        .clk(clk_100m), .rst_n(reset_n), .clr(per_clr), .inc(per_inc), .cnt(per_cnt)
    );

    sat_counter #(.W(CNT_W)) u_hi_cnt (
        .clk(clk_100m), .rst_n(reset_n), .clr(per_clr), .inc(hi_inc), .cnt(hi_cnt)
    );

    sat_counter #(.W(CNT_W)) u_to_cnt (
        .clk(clk_100m), .rst_n(reset_n), .clr(to_clr), .inc(enable), .cnt(to_cnt)
    );

    sat_counter #(.W(16)) u_glitch_cnt (
        .clk(clk_100m), .rst_n(reset_n), .clr(1'b0), .inc(glitch_inc), .cnt(glitch_cnt)
    );

    assign period     = period_q;
    assign high_time  = high_time_q;
    assign meas_valid = meas_valid_q;
    assign sig_lost   = sig_lost_q;
    assign edge_err   = edge_err_q;

endmodule

// File: tb/tb_sig_period_meter.sv
// Directed bench for sig_period_meter: table of rise-to-rise periods plus timeout, edge error and reset sequences.
module tb_sig_period_meter;

    logic        clk_100m;
    logic        reset_n;
    logic        enable;
    logic        sig_l2h;
    logic        sig_h2l;
    logic [31:0] period;
    logic [31:0] high_time;
    logic        meas_valid;
    logic        sig_lost;
    logic        edge_err;
    logic [15:0] glitch_cnt;

    int tests;
    int fails;

    sig_period_meter #(
        .CNT_W(32),
        .TIMEOUT_CYC(1000),
        .MIN_PERIOD(4)
    ) dut (
        .clk_100m(clk_100m),
        .reset_n(reset_n),
        .enable(enable),
        .sig_l2h(sig_l2h),
        .sig_h2l(sig_h2l),
        .period(period),
        .high_time(high_time),
        .meas_valid(meas_valid),
        .sig_lost(sig_lost),
        .edge_err(edge_err),
        .glitch_cnt(glitch_cnt)
    );

    initial begin
        clk_100m = 1'b0;
        forever #5 clk_100m = ~clk_100m;
    end

    typedef struct {
        int          gap;     // cycles from previous rise to closing rise
        int          hi;      // offset of the falling strobe, 0 = none
        logic        vld;
        logic [31:0] per;
        logic [31:0] hit;
        logic [15:0] gl;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drive strobes for one cycle; outputs are read 1 time unit after the edge.
    task automatic step(input logic l2h, input logic h2l);
        sig_l2h = l2h;
        sig_h2l = h2l;
        @(posedge clk_100m);
        #1;
        sig_l2h = 1'b0;
        sig_h2l = 1'b0;
    endtask

    task automatic run_period(input int p, input int h);
        logic spur;
        spur = 1'b0;
        for (int k = 1; k < p; k++) begin
            step(1'b0, k == h);
            if (meas_valid !== 1'b0) spur = 1'b1;
        end
        step(1'b1, 1'b0);
        check("no_stray_vld", 32'(spur), 32'd0);
    endtask

    initial begin
        logic spur;
        tests   = 0;
        fails   = 0;
        reset_n = 1'b0;
        enable  = 1'b0;
        sig_l2h = 1'b0;
        sig_h2l = 1'b0;

        // Scaled-down 30% duty waveform, glitches, exact-minimum and missed-fall periods.
        vecs[0] = '{600, 180, 1'b1, 32'd600, 32'd180, 16'd0};
        vecs[1] = '{600, 180, 1'b1, 32'd600, 32'd180, 16'd0};
        vecs[2] = '{400, 100, 1'b1, 32'd400, 32'd100, 16'd0};
        vecs[3] = '{3,   0,   1'b0, 32'd400, 32'd100, 16'd1};
        vecs[4] = '{100, 40,  1'b1, 32'd100, 32'd40,  16'd1};
        vecs[5] = '{50,  0,   1'b1, 32'd50,  32'd50,  16'd1};
        vecs[6] = '{4,   2,   1'b1, 32'd4,   32'd2,   16'd1};
        vecs[7] = '{3,   1,   1'b0, 32'd4,   32'd2,   16'd2};
        vecs[8] = '{5,   0,   1'b1, 32'd5,   32'd5,   16'd2};

        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        check("rst_period", period, 32'd0);
        check("rst_high", high_time, 32'd0);
        check("rst_vld", 32'(meas_valid), 32'd0);
        check("rst_lost", 32'(sig_lost), 32'd0);
        check("rst_eerr", 32'(edge_err), 32'd0);
        check("rst_glitch", 32'(glitch_cnt), 32'd0);

        reset_n = 1'b1;
        enable  = 1'b1;
        step(1'b0, 1'b0);
        step(1'b1, 1'b0);
        check("first_rise_vld", 32'(meas_valid), 32'd0);

        foreach (vecs[i]) begin
            run_period(vecs[i].gap, vecs[i].hi);
            check($sformatf("v%0d_vld", i), 32'(meas_valid), 32'(vecs[i].vld));
            check($sformatf("v%0d_period", i), period, vecs[i].per);
            check($sformatf("v%0d_high", i), high_time, vecs[i].hit);
            check($sformatf("v%0d_glitch", i), 32'(glitch_cnt), 32'(vecs[i].gl));
            check($sformatf("v%0d_lost", i), 32'(sig_lost), 32'd0);
        end

        // Loss of signal: the 1000th cycle after the last rise raises sig_lost.
        spur = 1'b0;
        for (int k = 0; k < 998; k++) begin
            step(1'b0, k == 10);
            if (meas_valid !== 1'b0 || sig_lost !== 1'b0) spur = 1'b1;
        end
        check("pre_timeout_quiet", 32'(spur), 32'd0);
        step(1'b0, 1'b0);
        check("timeout_lost", 32'(sig_lost), 32'd1);
        check("timeout_vld", 32'(meas_valid), 32'd0);
        for (int k = 0; k < 5; k++) step(1'b0, 1'b0);
        check("lost_held", 32'(sig_lost), 32'd1);
        step(1'b1, 1'b0);
        check("lost_cleared", 32'(sig_lost), 32'd0);
        check("after_lost_first_vld", 32'(meas_valid), 32'd0);
        check("after_lost_period_kept", period, 32'd5);
        run_period(200, 60);
        check("resume_vld", 32'(meas_valid), 32'd1);
        check("resume_period", period, 32'd200);
        check("resume_high", high_time, 32'd60);

        // Simultaneous strobes are ignored and latch edge_err until enable drops.
        step(1'b1, 1'b1);
        check("eerr_set", 32'(edge_err), 32'd1);
        check("eerr_no_vld", 32'(meas_valid), 32'd0);
        for (int k = 0; k < 3; k++) step(1'b0, 1'b0);
        check("eerr_sticky", 32'(edge_err), 32'd1);
        enable = 1'b0;
        step(1'b1, 1'b0);
        enable = 1'b1;
        check("eerr_cleared", 32'(edge_err), 32'd0);
        check("dis_period_kept", period, 32'd200);
        check("dis_high_kept", high_time, 32'd60);
        check("dis_glitch_kept", 32'(glitch_cnt), 32'd2);
        check("dis_vld", 32'(meas_valid), 32'd0);
        step(1'b1, 1'b0);
        check("reenable_first_vld", 32'(meas_valid), 32'd0);
        run_period(20, 5);
        check("reenable_period", period, 32'd20);
        check("reenable_high", high_time, 32'd5);

        // Asynchronous reset 20 cycles into a period.
        for (int k = 0; k < 19; k++) step(1'b0, k == 4);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_period", period, 32'd0);
        check("arst_high", high_time, 32'd0);
        check("arst_glitch", 32'(glitch_cnt), 32'd0);
        check("arst_vld", 32'(meas_valid), 32'd0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        reset_n = 1'b1;
        step(1'b1, 1'b0);
        check("post_rst_first_vld", 32'(meas_valid), 32'd0);
        run_period(30, 10);
        check("post_rst_vld", 32'(meas_valid), 32'd1);
        check("post_rst_period", period, 32'd30);
        check("post_rst_high", high_time, 32'd10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sig_period_meter.md
Name: sig_period_meter

Overview:
- Consumes the single-cycle rising-edge and falling-edge strobes produced by the edge-detect stage for one external digital signal, e.g. a PPS or sync input on the ADC board.
- Measures period (rise to rise) and high time (rise to fall) in clk_100m cycles.
- Presents each completed measurement with a one-cycle valid strobe to the register/CPU interface.
- Flags loss of signal after a programmable timeout.

Parameters:
- CNT_W, 32, width of the cycle counters and measurement outputs.
- TIMEOUT_CYC, 100_000_000, cycles with no rising edge before signal loss is declared (1 s at 100 MHz).
- MIN_PERIOD, 4, minimum accepted period in cycles; shorter periods are rejected as glitches.

Ports:
- clk_100m  in  1  system clock, 100 MHz.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  measurement enable; low forces IDLE.
- sig_l2h  in  1  single-cycle rising-edge strobe from the edge detector.
- sig_h2l  in  1  single-cycle falling-edge strobe from the edge detector.
- period  out  CNT_W  last accepted period in cycles.
- high_time  out  CNT_W  high time belonging to the last accepted period.
- meas_valid  out  1  one-cycle strobe: period/high_time updated this cycle.
- sig_lost  out  1  level, high while no rising edge seen for TIMEOUT_CYC cycles.
- edge_err  out  1  sticky: sig_l2h and sig_h2l were asserted in the same cycle.
- glitch_cnt  out  16  saturating count of rejected short periods.

Behaviour:
- Reset is asynchronous, active-low, single clock domain.
- Reset values: all outputs 0; state = IDLE; internal counters 0.
- State machine states:
  - IDLE: waiting for the first rising edge.
  - HIGH: signal high; counting period and high time.
  - LOW: signal low; counting period.
- Transitions:
  - IDLE -> HIGH on sig_l2h: period counter := 1, high counter := 1.
  - HIGH -> LOW on sig_h2l: latch high counter into a pending high-time register.
  - LOW -> HIGH on sig_l2h: close the period (accept or reject, see below); counters restart at 1.
  - HIGH with sig_l2h (missed falling edge): close the period with pending high time := current high counter.
  - LOW with sig_h2l: ignored.
- Period close rules:
  - Closing period value = period counter. It is the number of clk_100m cycles from one sig_l2h to the next, inclusive of the closing cycle.
  - If value >= MIN_PERIOD: on the next clock, period := value, high_time := pending high time, meas_valid = 1 for exactly one cycle. Latency is 1 cycle after the sig_l2h cycle.
  - If value < MIN_PERIOD: no update, glitch_cnt += 1 (saturates at 0xFFFF). The state machine still restarts from this edge.
- Counters:
  - Increment every cycle in HIGH/LOW and saturate at all-ones; they never wrap.
  - A saturated period is reported as all-ones.
- Timeout:
  - A separate cycles-since-last-rise counter runs in all states while enable = 1.
  - When it reaches TIMEOUT_CYC, sig_lost := 1 and state -> IDLE; the partial measurement is discarded, no meas_valid.
  - sig_lost clears on the next sig_l2h, which is handled as IDLE -> HIGH.
- Simultaneous sig_l2h and sig_h2l in one cycle:
  - Both are ignored and edge_err := 1.
  - edge_err is cleared only by reset or by enable going low.
- enable low:
  - State -> IDLE, counters cleared, meas_valid held 0, sig_lost := 0, edge_err := 0.
  - period, high_time and glitch_cnt hold their last values.
- First rising edge after IDLE never produces meas_valid; at least two rising edges are needed.
- Reset mid-measurement: everything returns to reset values immediately; no meas_valid is emitted.

Decomposition:
- Shared package sig_meas_pkg:
  - state enum (IDLE, HIGH, LOW);
  - default constants CLK_HZ = 100_000_000, DEF_TIMEOUT_CYC, DEF_MIN_PERIOD.
- One natural sub-module: sat_counter (parameterised width, clear, enable, saturate at all-ones). It is instantiated for the period, high-time, timeout and glitch counters.

Test Plan:
- Reset, then a 1 kHz input with 30% duty (rise every 100000 cycles, high for 30000) -> second rise gives meas_valid one cycle later with period = 100000, high_time = 30000. Repeats every period; the first rise produces no strobe.
- Rises 3 cycles apart with MIN_PERIOD = 4 -> no meas_valid, glitch_cnt = 1. The next rise 100 cycles later -> period = 100.
- Stop the input for TIMEOUT_CYC = 1000 (bench override) -> sig_lost = 1 at cycle 1000 after the last rise, no meas_valid. The next rise clears sig_lost; valid resumes after two rises.
- Assert sig_l2h and sig_h2l in the same cycle -> edge_err = 1 and stays 1. Drop enable for 1 cycle -> edge_err = 0, period unchanged.
- Rise, then a rise 50 cycles later with no fall -> meas_valid with period = 50, high_time = 50.
- Assert reset_n low mid-period, 20 cycles after a rise -> outputs 0 asynchronously. After release, the first rise produces no meas_valid.
